// File: rtl/mac_arbiter_if.sv
// Signal bundle between two MAC requesters, the shared MAC and the response sink.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mac_arbiter_if;
  logic        req0_valid, req0_ready, req0_signed, req0_last;
  logic [7:0]  req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_signed, req1_last;
  logic [7:0]  req1_a, req1_b;

  logic [7:0]  mac_data_a, mac_data_b;
  logic        mac_clear_and_mult, mac_signed_mode, mac_valid;
  logic [15:0] mac_result;
  logic        mac_overflow;

  logic        rsp_valid, rsp_ready, rsp_id, rsp_overflow, rsp_timeout;
  logic [15:0] rsp_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_signed, req0_last,
    input  req1_valid, req1_a, req1_b, req1_signed, req1_last,
    input  mac_result, mac_overflow, rsp_ready,
    output req0_ready, req1_ready,
    output mac_data_a, mac_data_b, mac_clear_and_mult, mac_signed_mode, mac_valid,
    output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_timeout
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_signed, req0_last,
    output req1_valid, req1_a, req1_b, req1_signed, req1_last,
    output mac_result, mac_overflow, rsp_ready,
    input  req0_ready, req1_ready,
    input  mac_data_a, mac_data_b, mac_clear_and_mult, mac_signed_mode, mac_valid,
    input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_timeout
  );
endinterface

// File: rtl/mac_arbiter.sv
// Two-requester round-robin arbiter in front of a pipelined MAC, with job locking and response capture.
// Optional grant watchdog enabled by defining MAC_ARB_TIMEOUT_EN.
module mac_arbiter #(
  parameter int MAC_LATENCY    = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          rst_n,
  mac_arbiter_if.slave bus
);
  localparam int L = MAC_LATENCY;

  if (MAC_LATENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mac_arbiter: MAC_LATENCY and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESP} state_t;

  state_t        state_q;
  logic          grant_q, prio_q, first_q, signed_q;
  logic          ready0_q, ready1_q;
  logic [L-1:0]  tag_q;
  logic          rsp_valid_q, rsp_id_q, rsp_overflow_q;
  logic [15:0]   rsp_result_q;
`ifdef MAC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt_q;
  logic [L-1:0]  flight_q;
  logic          timed_out_q, rsp_timeout_q;
`endif

  logic       g_valid, g_signed, g_last, pick_g, beat;
  logic [7:0] g_a, g_b;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    g_valid  = bus.req0_valid;
    g_a      = bus.req0_a;
    g_b      = bus.req0_b;
    g_signed = bus.req0_signed;
    g_last   = bus.req0_last;
    if (grant_q) begin
      g_valid  = bus.req1_valid;
      g_a      = bus.req1_a;
      g_b      = bus.req1_b;
      g_signed = bus.req1_signed;
      g_last   = bus.req1_last;
    end
    pick_g = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
  end

  // Readies are only ever raised for the granted requester, so this is the accept strobe.
  assign beat = g_valid & (grant_q ? ready1_q : ready0_q);

  assign bus.req0_ready         = ready0_q;
  assign bus.req1_ready         = ready1_q;
  assign bus.mac_valid          = beat;
  assign bus.mac_data_a         = beat ? g_a : 8'd0;
  assign bus.mac_data_b         = beat ? g_b : 8'd0;
  assign bus.mac_clear_and_mult = beat & first_q;
  assign bus.mac_signed_mode    = beat & (first_q ? g_signed : signed_q);
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_id             = rsp_id_q;
  assign bus.rsp_result         = rsp_result_q;
  assign bus.rsp_overflow       = rsp_overflow_q;
`ifdef MAC_ARB_TIMEOUT_EN
  assign bus.rsp_timeout        = rsp_timeout_q;
`else
  assign bus.rsp_timeout        = 1'b0;
`endif

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_q        <= 1'b0;
      prio_q         <= 1'b0;
      first_q        <= 1'b0;
      signed_q       <= 1'b0;
      ready0_q       <= 1'b0;
      ready1_q       <= 1'b0;
      // NOTE: the tag pipeline is reset too; a stale tag would fabricate a response after reset.
      tag_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
`ifdef MAC_ARB_TIMEOUT_EN
      idle_cnt_q     <= '0;
      flight_q       <= '0;
      timed_out_q    <= 1'b0;
      rsp_timeout_q  <= 1'b0;
`endif
    end else begin
      tag_q <= (tag_q << 1) | L'(beat & g_last);
`ifdef MAC_ARB_TIMEOUT_EN
      flight_q <= (flight_q << 1) | L'(beat);
`endif
      case (state_q)
        IDLE: begin
          if (bus.req0_valid || bus.req1_valid) begin
            grant_q  <= pick_g;
            prio_q   <= ~pick_g;
            ready0_q <= ~pick_g;
            ready1_q <= pick_g;
            first_q  <= 1'b1;
            state_q  <= STREAM;
`ifdef MAC_ARB_TIMEOUT_EN
            idle_cnt_q  <= '0;
            timed_out_q <= 1'b0;
`endif
          end
        end
        STREAM: begin
          if (beat) begin
            first_q <= 1'b0;
            if (first_q) signed_q <= g_signed;
            if (g_last) begin
              ready0_q <= 1'b0;
              ready1_q <= 1'b0;
              state_q  <= DRAIN;
            end
`ifdef MAC_ARB_TIMEOUT_EN
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
            timed_out_q <= 1'b1;
            state_q     <= DRAIN;
          end else begin
            idle_cnt_q <= idle_cnt_q + CW'(1);
`endif
          end
        end
        DRAIN: begin
`ifdef MAC_ARB_TIMEOUT_EN
          // An abandoned job still lets issued beats leave the MAC before answering.
          if (timed_out_q) begin
            if (flight_q == '0) begin
              rsp_result_q   <= '0;
              rsp_overflow_q <= 1'b0;
              rsp_timeout_q  <= 1'b1;
              rsp_id_q       <= grant_q;
              rsp_valid_q    <= 1'b1;
              state_q        <= RESP;
            end
          end else
`endif
          if (tag_q[L-1]) begin
            rsp_result_q   <= bus.mac_result;
            rsp_overflow_q <= bus.mac_overflow;
            rsp_id_q       <= grant_q;
            rsp_valid_q    <= 1'b1;
            state_q        <= RESP;
`ifdef MAC_ARB_TIMEOUT_EN
            rsp_timeout_q  <= 1'b0;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_arbiter.sv
// Directed self-checking bench for mac_arbiter with a behavioural pipelined MAC stand-in.
// Define MAC_ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_mac_arbiter;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mac_arbiter_if bus ();

  mac_arbiter #(.MAC_LATENCY(LAT), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: accumulate on each issued beat, result visible LAT cycles later.
  int          acc_m = 0;
  logic        ovf_m = 1'b0;
  logic [15:0] res_pipe [LAT];
  logic        ovf_pipe [LAT];

  always @(posedge clk) begin : mac_model
    int   pa, pb, nacc;
    logic novf;
    nacc = acc_m;
    novf = ovf_m;
    if (bus.mac_valid) begin
      pa = bus.mac_signed_mode ? int'({{24{bus.mac_data_a[7]}}, bus.mac_data_a}) : int'({24'd0, bus.mac_data_a});
      pb = bus.mac_signed_mode ? int'({{24{bus.mac_data_b[7]}}, bus.mac_data_b}) : int'({24'd0, bus.mac_data_b});
      nacc = (bus.mac_clear_and_mult ? 0 : acc_m) + pa * pb;
      novf = (bus.mac_clear_and_mult ? 1'b0 : ovf_m) |
             (bus.mac_signed_mode ? (nacc > 32767 || nacc < -32768) : (nacc > 65535));
    end
    acc_m       <= nacc;
    ovf_m       <= novf;
    res_pipe[0] <= nacc[15:0];
    ovf_pipe[0] <= novf;
    for (int i = 1; i < LAT; i++) begin
      res_pipe[i] <= res_pipe[i-1];
      ovf_pipe[i] <= ovf_pipe[i-1];
    end
  end

  assign bus.mac_result   = res_pipe[LAT-1];
  assign bus.mac_overflow = ovf_pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_of(input bit id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  task automatic drive(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b,
                       input bit sgn, input bit last);
    if (id) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_signed = sgn; bus.req1_last = last;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_signed = sgn; bus.req0_last = last;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one beat, waits for ready, checks the MAC-side view, and returns just after the accepting edge.
  task automatic send_beat(input bit id, input logic [7:0] a, input logic [7:0] b, input bit sgn,
                           input bit last, input bit exp_clr, input bit exp_sgn, input string tag);
    int n = 0;
    @(negedge clk);
    drive(id, 1'b1, a, b, sgn, last);
    while (ready_of(id) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(ready_of(id)), 32'd1);
    #1;
    check({tag, "_mv"}, 32'(bus.mac_valid), 32'd1);
    check({tag, "_ab"}, {16'd0, bus.mac_data_a, bus.mac_data_b}, {16'd0, a, b});
    check({tag, "_clr"}, 32'(bus.mac_clear_and_mult), 32'(exp_clr));
    check({tag, "_sgn"}, 32'(bus.mac_signed_mode), 32'(exp_sgn));
    check({tag, "_other"}, 32'(ready_of(~id)), 32'd0);
    @(posedge clk);
    #1;
    drive(id, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  // Waits for a response, checks latency and fields, holds rsp_ready low for hold cycles, then handshakes.
  task automatic wait_rsp(input bit id, input logic [15:0] res, input bit ovf, input int lat,
                          input int hold, input string tag);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    check({tag, "_res"}, 32'(bus.rsp_result), 32'(res));
    check({tag, "_ovf"}, 32'(bus.rsp_overflow), 32'(ovf));
    check({tag, "_to"}, 32'(bus.rsp_timeout), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_v"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_hold_res"}, 32'(bus.rsp_result), 32'(res));
      check({tag, "_hold_rdy"}, {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_done"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int grants [4];
    int both, ng, cnt, n;

    // Reset: outputs stay zero even with requests pending.
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 8'd3, 8'd3, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 8'd5, 8'd5, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_ready", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    check("rst_mac", {13'd0, bus.mac_valid, bus.mac_data_a, bus.mac_data_b, bus.mac_clear_and_mult,
                      bus.mac_signed_mode}, 32'd0);
    check("rst_rsp", {12'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout}, 32'd0);
    do_reset();

    // Three-beat unsigned job with an idle gap before the last beat: 12+30+14 = 56.
    send_beat(1'b0, 8'd3, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0, "j1b0");
    send_beat(1'b0, 8'd5, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0, "j1b1");
    repeat (2) begin
      @(negedge clk);
      check("gap_mac", {15'd0, bus.mac_valid, bus.mac_data_a, bus.mac_data_b, bus.mac_clear_and_mult}, 32'd0);
      check("gap_grant_held", 32'(bus.req0_ready), 32'd1);
    end
    send_beat(1'b0, 8'd2, 8'd7, 1'b0, 1'b1, 1'b0, 1'b0, "j1b2");
    check("j1_drain_rdy", 32'(bus.req0_ready), 32'd0);
    wait_rsp(1'b0, 16'h0038, 1'b0, LAT, 0, "j1");

    // Signed single-beat job from requester 1: -3*5 = -15.
    send_beat(1'b1, 8'hFD, 8'd5, 1'b1, 1'b1, 1'b1, 1'b1, "j2");
    wait_rsp(1'b1, 16'hFFF1, 1'b0, LAT, 0, "j2");

    // Unsigned overflow, second beat's signed flag ignored: 2*65025 = 130050 -> 0xFC02 with overflow.
    send_beat(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, "j3b0");
    send_beat(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, "j3b1");
    wait_rsp(1'b0, 16'hFC02, 1'b1, LAT, 0, "j3");

    // Response back-pressure for 5 cycles with the other requester waiting: 7*9 = 63.
    send_beat(1'b0, 8'd7, 8'd9, 1'b0, 1'b1, 1'b1, 1'b0, "j4");
    drive(1'b1, 1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
    wait_rsp(1'b0, 16'h003F, 1'b0, LAT, 5, "j4");
    check("j4_idle_gap", 32'(bus.req1_ready), 32'd0);
    @(posedge clk);
    #1;
    check("j4_next_grant", 32'(bus.req1_ready), 32'd1);
    do_reset();

    // Both requesters continuously valid with single-beat jobs: grants alternate from requester 0.
    bus.rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'd2, 8'd2, 1'b0, 1'b1);
    grants = '{default: -1};
    both = 0;
    ng = 0;
    for (int cyc = 0; cyc < 200 && ng < 4; cyc++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) both++;
      if (bus.req0_ready || bus.req1_ready) begin
        grants[ng] = int'(bus.req1_ready);
        ng++;
      end
    end
    check("rr_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    check("rr_both_ready", 32'(both), 32'd0);
    do_reset();

    // Reset asserted during DRAIN: outputs drop at once and the job never answers.
    send_beat(1'b0, 8'd4, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, "j5");
    #2;
    rst_n = 1'b0;
    #1;
    check("drain_rst_out", {14'd0, bus.req0_ready, bus.req1_ready, bus.mac_valid, bus.rsp_valid,
                            bus.rsp_id, bus.rsp_overflow, bus.rsp_timeout, 9'd0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) cnt++;
    end
    check("drain_rst_no_rsp", 32'(cnt), 32'd0);
    do_reset();

    // Grant on the first edge after reset release, then the requester goes silent.
    drive(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("first_grant", 32'(bus.req0_ready), 32'd1);
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
`ifdef MAC_ARB_TIMEOUT_EN
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("to_lat_window", 32'(n >= 16 && n <= 18), 32'd1);
    check("to_flag", 32'(bus.rsp_timeout), 32'd1);
    check("to_fields", {14'd0, bus.rsp_result, bus.rsp_overflow, bus.rsp_id}, 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("to_done", 32'(bus.rsp_valid), 32'd0);
`else
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) cnt++;
    end
    n = int'(bus.req0_ready);
    check("no_to_rsp", 32'(cnt), 32'd0);
    check("no_to_grant_held", 32'(n), 32'd1);
    check("no_to_flag", 32'(bus.rsp_timeout), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
